// File: rtl/spi_ram_if.sv
// rtl/spi_ram_if.sv - command/response bundle between the SPI slave and spi_ram
interface spi_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  // SPI slave side: issues command words, consumes read data
  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  // RAM side: consumes command words, returns read data
  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command-driven single-port RAM behind the SPI slave; optional SPI_RAM_AUTOINC_EN address auto-increment
module spi_ram #(
  parameter int MEM_DEPTH      = 256,
  parameter int ADDR_SIZE      = 8,
  parameter int TX_HOLD_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  spi_ram_if.slave     bus
);

  localparam int CW = $clog2(TX_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    TX_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_rx_valid_d;
  logic [ADDR_SIZE-1:0]   r_wr_addr;
  logic [ADDR_SIZE-1:0]   r_rd_addr;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic [CW-1:0]          r_cnt;
  logic [7:0]             r_mem [0:MEM_DEPTH-1];

  state_t                 w_state_n;
  logic [ADDR_SIZE-1:0]   w_wr_addr_n;
  logic [ADDR_SIZE-1:0]   w_rd_addr_n;
  logic [7:0]             w_tx_data_n;
  logic                   w_tx_valid_n;
  logic [CW-1:0]          w_cnt_n;
  logic                   w_mem_we;
  logic                   w_exec;
  logic                   w_accept;
  logic [1:0]             w_opcode;
  logic [7:0]             w_payload;

`ifdef SPI_RAM_AUTOINC_EN
  logic                   r_wr_inc;
  logic                   w_wr_inc_n;
`endif

  // A long rx_valid level counts as one command: only its rising edge is accepted
  assign w_accept  = bus.rx_valid & ~r_rx_valid_d;
  assign w_opcode  = bus.rx_data[9:8];
  assign w_payload = bus.rx_data[7:0];

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;

  // Next-state and datapath decode; a command accepted in TX_HOLD cuts the hold short and runs as from IDLE
  always_comb begin
    w_state_n    = r_state;
    w_wr_addr_n  = r_wr_addr;
    w_rd_addr_n  = r_rd_addr;
    w_tx_data_n  = r_tx_data;
    w_tx_valid_n = r_tx_valid;
    w_cnt_n      = r_cnt;
    w_mem_we     = 1'b0;
    w_exec       = 1'b0;
`ifdef SPI_RAM_AUTOINC_EN
    w_wr_inc_n   = 1'b0;
    if (r_wr_inc) w_wr_addr_n = r_wr_addr + 1'b1;
`endif

    case (r_state)
      IDLE: begin
        w_exec = w_accept;
      end
      RD_PEND: begin
        w_tx_data_n  = r_mem[r_rd_addr];
        w_tx_valid_n = 1'b1;
        w_cnt_n      = CW'(TX_HOLD_CYCLES - 1);
        w_state_n    = TX_HOLD;
`ifdef SPI_RAM_AUTOINC_EN
        w_rd_addr_n  = r_rd_addr + 1'b1;
`endif
      end
      TX_HOLD: begin
        if (w_accept) begin
          w_tx_valid_n = 1'b0;
          w_state_n    = IDLE;
          w_exec       = 1'b1;
        end else if (r_cnt == '0) begin
          w_tx_valid_n = 1'b0;
          w_state_n    = IDLE;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    // Command execution; an address command here overrides any pending increment above
    if (w_exec) begin
      case (w_opcode)
        2'b00: w_wr_addr_n = bus.rx_data[ADDR_SIZE-1:0];
        2'b01: begin
          w_mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          w_wr_inc_n = 1'b1;
`endif
        end
        2'b10: w_rd_addr_n = bus.rx_data[ADDR_SIZE-1:0];
        default: w_state_n = RD_PEND;
      endcase
    end
  end

  // Control/state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rx_valid_d <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_cnt        <= '0;
`ifdef SPI_RAM_AUTOINC_EN
      r_wr_inc     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_rx_valid_d <= bus.rx_valid;
      r_wr_addr    <= w_wr_addr_n;
      r_rd_addr    <= w_rd_addr_n;
      r_tx_data    <= w_tx_data_n;
      r_tx_valid   <= w_tx_valid_n;
      r_cnt        <= w_cnt_n;
`ifdef SPI_RAM_AUTOINC_EN
      r_wr_inc     <= w_wr_inc_n;
`endif
    end
  end

  // Memory array is never reset; reset only blocks a write on its edge
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) r_mem[r_wr_addr] <= w_payload;
  end

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - directed self-checking bench for spi_ram
module tb_spi_ram;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  spi_ram_if bus ();

  spi_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it if observed differs from expected
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx_valid pulse followed by one low cycle; returns 1ns after the edge following the accept
  task automatic send(input logic [9:0] cmd);
    bus.rx_data  = cmd;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  // Number of consecutive cycles tx_valid stays high from now on (bounded)
  task automatic count_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    bus.rx_data  = 10'h000;
    bus.rx_valid = 1'b0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
    send(10'h300);
    check("uninit_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
    count_valid(n);
    check("uninit_hold_len", n, 8);

    // Write/read back
    send(10'h012);
    send(10'h1A5);
    send(10'h212);
    send(10'h300);
    check("rb_tx_data", {24'd0, bus.tx_data}, 32'hA5);
    check("rb_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
    count_valid(n);
    check("rb_hold_len", n, 8);
    check("rb_data_kept", {24'd0, bus.tx_data}, 32'hA5);

    // Level rx_valid counts as a single write
    send(10'h021);
    send(10'h15A);
    send(10'h020);
    bus.rx_data  = 10'h1FF;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    bus.rx_valid = 1'b0;
    tick();
    send(10'h220);
    send(10'h300);
    check("lvl_mem20", {24'd0, bus.tx_data}, 32'hFF);
    count_valid(n);
    send(10'h221);
    send(10'h300);
    check("lvl_mem21", {24'd0, bus.tx_data}, 32'h5A);
    count_valid(n);

    // Write-data followed by read-data two cycles later sees the new value
    send(10'h250);
    send(10'h050);
    send(10'h1AB);
    send(10'h300);
    check("wr_then_rd", {24'd0, bus.tx_data}, 32'hAB);
    count_valid(n);

    // Hold abort by a write-address accept three cycles into the hold
    send(10'h030);
    send(10'h177);
    send(10'h230);
    send(10'h300);
    check("abort_pre_valid", {31'd0, bus.tx_valid}, 32'd1);
    tick();
    tick();
    bus.rx_data  = 10'h040;
    bus.rx_valid = 1'b1;
    tick();
    check("abort_valid_fall", {31'd0, bus.tx_valid}, 32'd0);
    bus.rx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx_valid !== 1'b0) n++;
    end
    check("abort_stays_idle", n, 0);
    check("abort_data_kept", {24'd0, bus.tx_data}, 32'h77);
    send(10'h1C3);
    send(10'h240);
    send(10'h300);
    check("abort_wr_addr", {24'd0, bus.tx_data}, 32'hC3);
    count_valid(n);

`ifdef SPI_RAM_AUTOINC_EN
    // Auto-increment wraps at the top of memory
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    send(10'h300);
    check("wrap_rd_ff", {24'd0, bus.tx_data}, 32'h11);
    count_valid(n);
    send(10'h300);
    check("wrap_rd_00", {24'd0, bus.tx_data}, 32'h22);
    count_valid(n);
`endif

    // Reset on the RD_PEND cycle aborts the read
    bus.rx_data  = 10'h300;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midrst_tx_data", {24'd0, bus.tx_data}, 32'h00);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx_valid !== 1'b0) n++;
    end
    check("midrst_no_valid", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port command-driven memory that consumes the 10-bit words assembled by the SPI slave and returns 8-bit read data to it. rx_data[9:8] selects one of four operations (write address, write data, read address, read data); rx_data[7:0] carries the payload. Sits directly downstream of the SPI slave on `rx_data`/`rx_valid` and feeds its `tx_data`/`tx_valid` inputs. Together the two blocks form the SPI-to-RAM path.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**ADDR_SIZE.
- `ADDR_SIZE`, 8: address width; payload bits [ADDR_SIZE-1:0] are used as the address.
- `TX_HOLD_CYCLES`, 8: cycles `tx_valid` stays high per read, so the slave can shift out all 8 bits.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  10  command word from the SPI slave: [9:8] opcode, [7:0] payload.
- `rx_valid`  in  1  level-high while `rx_data` is complete; may stay high for many cycles.
- `tx_data`  out  8  read data to the SPI slave.
- `tx_valid`  out  1  high while `tx_data` is valid for shifting.

## Operation
- Edge detect: register `rx_valid_d`. A command is accepted only on `rx_valid & ~rx_valid_d` (accept cycle). A long `rx_valid` level is one command.
- Opcodes:
  - 2'b00, write address: `wr_addr <= rx_data[ADDR_SIZE-1:0]`.
  - 2'b01, write data: `mem[wr_addr] <= rx_data[7:0]`.
  - 2'b10, read address: `rd_addr <= rx_data[ADDR_SIZE-1:0]`.
  - 2'b11, read data: payload ignored; starts a read of `mem[rd_addr]`.
- FSM states and transitions:
  - IDLE:
    - Accepted 2'b11 goes to RD_PEND.
    - Other opcodes execute and stay in IDLE.
  - RD_PEND, one cycle: `tx_data <= mem[rd_addr]`, `tx_valid <= 1`, hold counter loaded with TX_HOLD_CYCLES-1, go to TX_HOLD.
  - TX_HOLD: counter decrements each cycle.
    - At 0: `tx_valid <= 0`, go to IDLE.
    - An accepted command in TX_HOLD ends the hold: `tx_valid <= 0` on that edge. The command then executes exactly as from IDLE, including a new 2'b11 going to RD_PEND.
- `tx_data` keeps its last value after `tx_valid` falls.
- Memory contents are not reset. Only the registers listed under Timing are reset.
- Addresses wrap modulo MEM_DEPTH.
- No accept is possible in RD_PEND: the edge detector needs at least one low cycle between commands, and RD_PEND lasts exactly one cycle.

## Timing
- Reset values: `tx_data` = 8'h00, `tx_valid` = 0, `wr_addr` = 0, `rd_addr` = 0, `rx_valid_d` = 0, state = IDLE, hold counter = 0.
- `rst` overrides everything on the same edge. A read in progress is aborted and `tx_valid` is 0 the cycle after the reset edge.
- Write address, write data and read address take effect on the accept edge (edge N). A write-data accepted at N+1 uses the address written at N.
- Read-data accepted at edge N:
  - `tx_data`/`tx_valid` update at edge N+1.
  - `tx_valid` is high for exactly TX_HOLD_CYCLES cycles (edges N+1 .. N+TX_HOLD_CYCLES) unless cut short by a new accept.
- Write and read to the same address on the same accept cycle cannot happen (one opcode per accept). A write-data at N followed by a read-data at N+2 returns the new data.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - `wr_addr` increments by 1 (wrapping) on the edge after each write-data.
  - `rd_addr` increments by 1 (wrapping) in RD_PEND after the word is fetched.
  - A new address command on the same accept edge takes priority over a pending increment.
- Undefined: addresses change only on 2'b00 / 2'b10 commands.

## Test plan
- Reset then idle: assert `rst` 2 cycles → `tx_valid`=0, `tx_data`=8'h00; a read-data with no prior writes returns the uninitialised cell and raises no X on `tx_valid`.
- Write/read back: 10'h012, 10'h1A5, 10'h212, 10'h300 (each a single-cycle pulse, gaps ≥1) → `tx_data`=8'hA5 one cycle after the last accept, `tx_valid` high exactly 8 cycles.
- Level rx_valid: hold `rx_valid` high 12 cycles with 10'h1FF after address 8'h20 → exactly one write; reading 8'h20 returns 8'hFF and address 8'h21 is unchanged (macro off).
- Hold abort: read-data then a write-address accept 3 cycles into TX_HOLD → `tx_valid` falls on that edge, `wr_addr` updated, FSM in IDLE.
- Address wrap: with `SPI_RAM_AUTOINC_EN`, write address 8'hFF, data 8'h11 then 8'h22 → mem[FF]=11, mem[00]=22; reading from 8'hFF twice returns 11 then 22.
- Mid-read reset: `rst` on the RD_PEND cycle → `tx_valid` never asserts, `tx_data`=8'h00.
